// File: rtl/th_table_detect_if.sv
// Threshold-table write port, sample stream and compare-result bus for th_table_detect.
// The master drives table writes and samples; the slave returns ready and the per-bin results.
interface th_table_detect_if #(
   parameter int WN = 10,
   parameter int WL = 10,
   parameter int WD = 16
);
   logic          wr_en;
   logic [WN-1:0] wr_addr;
   logic [WL-1:0] wr_data;
   logic [1:0]    th_shift;
   logic          in_valid;
   logic [WD-1:0] in_data;
   logic          in_last;
   logic          ready;
   logic          out_valid;
   logic          out_hit;
   logic [WN-1:0] out_bin;
   logic          frame_done;
   logic [WN:0]   hit_count;

   modport master (
      output wr_en, wr_addr, wr_data, th_shift, in_valid, in_data, in_last,
      input  ready, out_valid, out_hit, out_bin, frame_done, hit_count
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, th_shift, in_valid, in_data, in_last,
      output ready, out_valid, out_hit, out_bin, frame_done, hit_count
   );
endinterface

// File: rtl/th_table_detect.sv
// Writable per-bin threshold table with a two-stage streaming compare and per-frame hit counter.
// After reset an init FSM zeroes every table entry before samples are accepted.
module th_table_detect #(
   parameter int WN   = 10,
   parameter int WL   = 10,
   parameter int WD   = 16,
   parameter int NBIN = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   th_table_detect_if.slave bus_io
);
   localparam int CW = (WD > WL + 3) ? WD : WL + 3;
   localparam int AW = WN + 1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t        state_q;
   logic          ready_q;
   logic [WN-1:0] init_cnt_q;
   logic [WN-1:0] bin_cnt_q;

   logic [WL-1:0] mem [2**WN];
   logic [WL-1:0] rd_q;

   logic          s1_valid_q;
   logic [WD-1:0] s1_data_q;
   logic [1:0]    s1_shift_q;
   logic [WN-1:0] s1_bin_q;
   logic          s1_last_q;

   logic          s2_valid_q;
   logic          s2_hit_q;
   logic [WN-1:0] s2_bin_q;
   logic          s2_last_q;

   logic          out_valid_q;
   logic          out_hit_q;
   logic [WN-1:0] out_bin_q;
   logic          frame_done_q;
   logic [AW-1:0] hit_count_q;
   logic [AW-1:0] acc_q;

   logic          accept_c;
   logic          last_c;
   logic          mem_we_c;
   logic [WN-1:0] mem_waddr_c;
   logic [WL-1:0] mem_wdata_c;
   logic [CW-1:0] thr_c;
   logic [CW-1:0] dat_c;
   logic          hit_c;
   logic [AW-1:0] acc_inc_c;

   always_comb begin
      accept_c    = bus_io.in_valid & ready_q;
      last_c      = bus_io.in_last | (bin_cnt_q == WN'(NBIN - 1));
      mem_we_c    = (state_q == ST_INIT) | (ready_q & bus_io.wr_en);
      mem_waddr_c = (state_q == ST_INIT) ? init_cnt_q : bus_io.wr_addr;
      mem_wdata_c = (state_q == ST_INIT) ? '0 : bus_io.wr_data;
      thr_c       = CW'(rd_q) << s1_shift_q;
      dat_c       = CW'(s1_data_q);
      hit_c       = dat_c > thr_c;
      acc_inc_c   = (&acc_q) ? acc_q : acc_q + AW'(s2_hit_q);
   end

   // Table storage has no reset; the init FSM clears it. The lookup reads before the write lands.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem[mem_waddr_c] <= mem_wdata_c;
      end
      if (accept_c) begin
         rd_q <= mem[bin_cnt_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         ready_q      <= 1'b0;
         init_cnt_q   <= '0;
         bin_cnt_q    <= '0;
         s1_valid_q   <= 1'b0;
         s1_data_q    <= '0;
         s1_shift_q   <= '0;
         s1_bin_q     <= '0;
         s1_last_q    <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_hit_q     <= 1'b0;
         s2_bin_q     <= '0;
         s2_last_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_hit_q    <= 1'b0;
         out_bin_q    <= '0;
         frame_done_q <= 1'b0;
         hit_count_q  <= '0;
         acc_q        <= '0;
      end else begin
         case (state_q)
            ST_INIT: begin
               init_cnt_q <= init_cnt_q + 1'b1;
               if (&init_cnt_q) begin
                  state_q <= ST_RUN;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_RUN;
               ready_q <= 1'b1;
            end
         endcase

         if (accept_c) begin
            bin_cnt_q <= last_c ? '0 : bin_cnt_q + 1'b1;
         end

         s1_valid_q <= accept_c;
         if (accept_c) begin
            s1_data_q  <= bus_io.in_data;
            s1_shift_q <= bus_io.th_shift;
            s1_bin_q   <= bin_cnt_q;
            s1_last_q  <= last_c;
         end

         s2_valid_q <= s1_valid_q;
         s2_hit_q   <= s1_valid_q & hit_c;
         s2_bin_q   <= s1_bin_q;
         s2_last_q  <= s1_valid_q & s1_last_q;

         // Result fields are forced to zero on bubble cycles.
         out_valid_q  <= s2_valid_q;
         out_hit_q    <= s2_valid_q & s2_hit_q;
         out_bin_q    <= s2_valid_q ? s2_bin_q : '0;
         frame_done_q <= s2_valid_q & s2_last_q;
         if (s2_valid_q) begin
            if (s2_last_q) begin
               hit_count_q <= acc_inc_c;
               acc_q       <= '0;
            end else begin
               acc_q <= acc_inc_c;
            end
         end
      end
   end

   assign bus_io.ready      = ready_q;
   assign bus_io.out_valid  = out_valid_q;
   assign bus_io.out_hit    = out_hit_q;
   assign bus_io.out_bin    = out_bin_q;
   assign bus_io.frame_done = frame_done_q;
   assign bus_io.hit_count  = hit_count_q;
endmodule

// File: tb/tb_th_table_detect.sv
// Directed bench for th_table_detect: vector table for compare/frame behaviour plus
// hand-written sequences for implicit wrap, read/write collision and mid-frame reset.
module tb_th_table_detect;
   localparam int WN   = 4;
   localparam int WL   = 10;
   localparam int WD   = 16;
   localparam int NBIN = 16;

   typedef struct {
      logic          we;
      logic [WN-1:0] wa;
      logic [WL-1:0] wd;
      logic [1:0]    sh;
      logic          vld;
      logic [WD-1:0] d;
      logic          last;
      logic          hit;
      logic [WN-1:0] bin;
      logic          fd;
      logic [WN:0]   cnt;
   } vec_t;

   typedef struct {
      logic          hit;
      logic [WN-1:0] bin;
      logic          fd;
      logic [WN:0]   cnt;
      int            acc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_err;
   int   cyc;
   exp_t sb[$];
   vec_t vecs[$];
   logic [WL-1:0] th_ref [2**WN];

   th_table_detect_if #(.WN(WN), .WL(WL), .WD(WD)) bus ();

   th_table_detect #(.WN(WN), .WL(WL), .WD(WD), .NBIN(NBIN)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle();
      bus.wr_en    = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.th_shift = '0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      cyc++;
      #1;
      if (bus.out_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 32'(bus.out_valid), 0);
         end else begin
            e = sb.pop_front();
            $display("result cyc=%0d bin=%0d hit=%0d frame_done=%0d hit_count=%0d",
                     cyc, bus.out_bin, bus.out_hit, bus.frame_done, bus.hit_count);
            chk("latency", 32'(cyc - e.acc), 2);
            chk("out_hit", 32'(bus.out_hit), 32'(e.hit));
            chk("out_bin", 32'(bus.out_bin), 32'(e.bin));
            chk("frame_done", 32'(bus.frame_done), 32'(e.fd));
            chk("hit_count", 32'(bus.hit_count), 32'(e.cnt));
         end
      end else begin
         chk("bubble_zero", 32'({bus.out_hit, bus.out_bin, bus.frame_done}), 0);
      end
   endtask

   task automatic drive(input vec_t v);
      exp_t e;
      bus.wr_en    = v.we;
      bus.wr_addr  = v.wa;
      bus.wr_data  = v.wd;
      bus.th_shift = v.sh;
      bus.in_valid = v.vld;
      bus.in_data  = v.d;
      bus.in_last  = v.last;
      if (v.we) th_ref[v.wa] = v.wd;
      if (v.vld) begin
         e.hit = v.hit; e.bin = v.bin; e.fd = v.fd; e.cnt = v.cnt; e.acc = cyc + 1;
         sb.push_back(e);
      end
      tick();
      idle();
   endtask

   task automatic add(input logic we, input int wa, input int wd, input int sh, input logic vld,
                      input int d, input logic last, input logic hit, input int bin,
                      input logic fd, input int cnt);
      vec_t v;
      v.we = we; v.wa = WN'(wa); v.wd = WL'(wd); v.sh = 2'(sh); v.vld = vld; v.d = WD'(d);
      v.last = last; v.hit = hit; v.bin = WN'(bin); v.fd = fd; v.cnt = (WN+1)'(cnt);
      vecs.push_back(v);
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
      chk("drain_timeout", 32'(sb.size()), 0);
   endtask

   task automatic init_wait();
      int n;
      n = 0;
      while (bus.ready !== 1'b1 && n < 100) begin
         tick();
         n++;
         chk("init_quiet", 32'({bus.out_valid, bus.out_hit, bus.out_bin, bus.frame_done, bus.hit_count}), 0);
      end
      chk("init_len", 32'(n), 32'(2**WN));
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, 32'({bus.ready, bus.out_valid, bus.out_hit, bus.out_bin, bus.frame_done, bus.hit_count}), 0);
   endtask

   initial begin
      vec_t v;
      int tot;
      logic h;
      clk = 1'b0; rst_n = 1'b0; n_checks = 0; n_err = 0; cyc = 0;
      for (int i = 0; i < 2**WN; i++) th_ref[i] = '0;
      idle();

      // we wa wd sh vld d last | hit bin fd cnt
      add(1, 5, 100, 0, 0, 0, 0,  0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0,    0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0,    0, 1, 0, 0);
      add(0, 0, 0, 0, 1, 1, 0,    1, 2, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0,    0, 3, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0,    0, 4, 0, 0);
      add(0, 0, 0, 0, 1, 101, 1,  1, 5, 1, 2);
      for (int b = 0; b < 5; b++) add(0, 0, 0, 0, 1, 0, 0, 0, b, 0, 2);
      add(0, 0, 0, 0, 1, 100, 1,  0, 5, 1, 0);
      add(1, 0, 100, 0, 0, 0, 0,  0, 0, 0, 0);
      add(1, 1, 100, 0, 0, 0, 0,  0, 0, 0, 0);
      add(1, 2, 1023, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 3, 1023, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 2, 1, 400, 0,  0, 0, 0, 0);
      add(0, 0, 0, 2, 1, 401, 0,  1, 1, 0, 0);
      add(0, 0, 0, 3, 1, 8184, 0, 0, 2, 0, 0);
      add(0, 0, 0, 3, 1, 8185, 1, 1, 3, 1, 2);
      add(0, 0, 0, 0, 1, 101, 0,  1, 0, 0, 2);
      add(0, 0, 0, 0, 1, 50, 0,   0, 1, 0, 2);
      add(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0,    0, 2, 0, 2);
      add(0, 0, 0, 0, 1, 2000, 0, 1, 3, 0, 2);
      add(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0,    0, 4, 0, 2);
      add(0, 0, 0, 0, 1, 100, 0,  0, 5, 0, 2);
      add(0, 0, 0, 0, 1, 7, 0,    1, 6, 0, 2);
      add(0, 0, 0, 0, 1, 0, 1,    0, 7, 1, 3);
      add(0, 0, 0, 0, 1, 0, 1,    0, 0, 1, 0);

      // Reset state and INIT length
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset_outputs");
      rst_n = 1'b1;
      init_wait();

      // Table-driven compare, gain, gap and frame vectors
      for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
      drain();

      // Implicit frame end at NBIN-1, then same-cycle write/lookup of bin 0
      tot = 0;
      for (int b = 0; b < NBIN; b++) begin
         h = (16'd1 > WD'(th_ref[b]));
         tot += int'(h);
         v = '{we:0, wa:0, wd:0, sh:0, vld:1, d:1, last:0, hit:h, bin:WN'(b),
               fd:(b == NBIN-1), cnt:(b == NBIN-1) ? (WN+1)'(tot) : '0};
         drive(v);
      end
      v = '{we:1, wa:0, wd:10, sh:0, vld:1, d:50, last:0, hit:0, bin:0, fd:0, cnt:(WN+1)'(tot)};
      drive(v);
      v = '{we:0, wa:0, wd:0, sh:0, vld:1, d:0, last:1, hit:0, bin:1, fd:1, cnt:0};
      drive(v);
      v = '{we:0, wa:0, wd:0, sh:0, vld:1, d:50, last:1, hit:1, bin:0, fd:1, cnt:1};
      drive(v);
      drain();

      // Reset with the pipeline full, then INIT ignoring writes and samples
      for (int b = 0; b < 3; b++) begin
         v = '{we:0, wa:0, wd:0, sh:0, vld:1, d:1, last:0, hit:0, bin:WN'(b), fd:0, cnt:1};
         drive(v);
      end
      rst_n = 1'b0;
      #1;
      chk_all_zero("midframe_reset");
      sb.delete();
      bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 10'd500;
      bus.in_valid = 1'b1; bus.in_data = 16'd1; bus.in_last = 1'b1;
      tick();
      chk_all_zero("reset_held");
      rst_n = 1'b1;
      init_wait();
      idle();
      for (int b = 0; b < NBIN; b++) begin
         v = '{we:0, wa:0, wd:0, sh:0, vld:1, d:1, last:0, hit:1, bin:WN'(b),
               fd:(b == NBIN-1), cnt:(b == NBIN-1) ? (WN+1)'(NBIN) : '0};
         drive(v);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
